// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage LoongArch pipeline.
//
// Produces the fetch PC (pre-IF), drives read requests to a synchronous
// instruction SRAM with one cycle of read latency, and hands {inst, pc} to
// decode over the fs_to_ds_valid / ds_allowin handshake. Decode's branch bus
// can redirect fetch (squashing the wrong-path slot) or stall it (flushing
// the slot and holding the PC).
//
// Parameters:
//   RESET_PC         address of the first instruction fetched after reset
//
// Ports:
//   clk              clock, rising edge
//   resetn           asynchronous active-low reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_bus[33:0]     {br_stall, br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid   fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus     {inst[63:32], pc[31:0]}
//   inst_sram_en     SRAM read request
//   inst_sram_we     SRAM byte write enables, always 4'h0
//   inst_sram_addr   SRAM read address (nextpc)
//   inst_sram_wdata  SRAM write data, always 32'h0
//   inst_sram_rdata  SRAM read data, valid the cycle after the request
//
// Build option:
//   IF_INST_BUF_EN   when defined, the instruction word of a slot that decode
//                    refuses in its first cycle is captured into a local
//                    buffer, so the SRAM output need not hold while en=0.
//                    When undefined, inst is always inst_sram_rdata and the
//                    SRAM must hold its output while en=0.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // The PC register starts one word before RESET_PC so that the ordinary
    // sequential increment produces RESET_PC as the first fetch address.
    localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

    // ------------------------------------------------------------------
    // Branch bus decode
    // ------------------------------------------------------------------
    logic        br_stall_s;
    logic        br_taken_s;
    logic [31:0] br_target_s;

    assign br_stall_s  = br_bus[33];
    assign br_taken_s  = br_bus[32];
    assign br_target_s = br_bus[31:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q,    fs_pc_d;
    logic        br_seen_q,  br_seen_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        redirect_s;
    logic [31:0] seq_pc_s;
    logic [31:0] nextpc_s;
    logic        fs_allowin_s;
    logic        fs_issue_s;
    logic        fs_out_valid_s;
    logic [31:0] inst_s;

    // Redirect / next-PC / issue decisions.
    // br_seen_q masks a taken branch that is still parked in decode after
    // its target has already been fetched, so the target is not re-fetched.
    // br_target is forwarded as-is; alignment is decode's concern.
    always_comb begin
        redirect_s     = br_taken_s && !br_stall_s && !br_seen_q;
        seq_pc_s       = fs_pc_q + 32'd4;
        if (redirect_s) begin
            nextpc_s = br_target_s;
        end else begin
            nextpc_s = seq_pc_s;
        end
        // A redirect frees the slot because the instruction in it is dead.
        fs_allowin_s   = !fs_valid_q || ds_allowin || redirect_s;
        fs_issue_s     = resetn && !br_stall_s && fs_allowin_s;
        // The wrong-path slot is never offered to decode in a redirect cycle.
        fs_out_valid_s = fs_valid_q && !redirect_s && !br_stall_s;
    end

    // Next state for slot valid, PC and the duplicate-branch flag.
    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        br_seen_d  = br_seen_q;

        if (br_stall_s) begin
            // Flush the slot, keep the PC so sequential fetch resumes from it.
            fs_valid_d = 1'b0;
        end else if (fs_issue_s) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc_s;
        end else begin
            fs_valid_d = fs_valid_q;
        end

        // The branch leaving decode (ds_allowin=1) ends suppression; this
        // takes priority over arming it. A stall leaves the flag alone.
        if (br_stall_s) begin
            br_seen_d = br_seen_q;
        end else if (ds_allowin) begin
            br_seen_d = 1'b0;
        end else if (redirect_s) begin
            br_seen_d = 1'b1;
        end else begin
            br_seen_d = br_seen_q;
        end
    end

    // Slot valid, PC and duplicate-branch flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= PC_RESET_VAL;
            br_seen_q  <= 1'b0;
        end else begin
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
            br_seen_q  <= br_seen_d;
        end
    end

`ifdef IF_INST_BUF_EN
    // ------------------------------------------------------------------
    // Instruction hold buffer
    // ------------------------------------------------------------------
    logic        fs_fresh_q,  fs_fresh_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;
    logic        buf_capture_s;
    logic        buf_drop_s;

    // Capture on the first cycle of a slot that decode refuses; the SRAM
    // output is only trustworthy in the cycle right after the request.
    always_comb begin
        fs_fresh_d    = fs_issue_s;
        buf_capture_s = fs_fresh_q && fs_out_valid_s && !ds_allowin;
        buf_drop_s    = redirect_s || br_stall_s || fs_issue_s ||
                        (fs_out_valid_s && ds_allowin);
        buf_valid_d   = buf_valid_q;
        inst_buf_d    = inst_buf_q;
        if (buf_drop_s) begin
            buf_valid_d = 1'b0;
        end else if (buf_capture_s) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram_rdata;
        end else begin
            buf_valid_d = buf_valid_q;
        end
    end

    // Hold-buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_fresh_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0000_0000;
        end else begin
            fs_fresh_q  <= fs_fresh_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    // Instruction source: buffered copy while one is held, else live SRAM.
    always_comb begin
        if (buf_valid_q) begin
            inst_s = inst_buf_q;
        end else begin
            inst_s = inst_sram_rdata;
        end
    end
`else
    // Instruction source: the SRAM holds its output while en=0.
    always_comb begin
        inst_s = inst_sram_rdata;
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fs_to_ds_valid  = fs_out_valid_s;
    assign fs_to_ds_bus    = {inst_s, fs_pc_q};
    assign inst_sram_en    = fs_issue_s;
    assign inst_sram_addr  = nextpc_s;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A behavioural synchronous SRAM returns mem_word(addr) one cycle after each
// request. Requests and deliveries seen by the monitor are queued; each test
// pushes the addresses / {inst,pc} words it expects and compares them against
// the observed queues, plus per-cycle inline checks of the handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        scramble;

    int n_tests;
    int n_fail;

    logic [31:0] exp_req[$];
    logic [31:0] obs_req[$];
    logic [63:0] exp_del[$];
    logic [63:0] obs_del[$];

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [33:0] br_take(input logic [31:0] t);
        return {1'b0, 1'b1, t};
    endfunction

    // Synchronous SRAM model; optionally garbles its output while idle.
    initial inst_sram_rdata = 32'h0000_0000;
    always @(posedge clk) begin
        if (inst_sram_en === 1'b1) inst_sram_rdata <= mem_word(inst_sram_addr);
        else if (scramble) inst_sram_rdata <= $urandom;
    end

    // Monitor: records requests and accepted deliveries.
    always @(negedge clk) begin
        if (resetn === 1'b1 && inst_sram_en === 1'b1) obs_req.push_back(inst_sram_addr);
        if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) obs_del.push_back(fs_to_ds_bus);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic a, input logic [33:0] b);
        ds_allowin = a;
        br_bus     = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_del(input logic [31:0] pc);
        exp_del.push_back({mem_word(pc), pc});
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        drive(1'b1, br_take(32'h1c00_0100));
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b exp 0", inst_sram_en); end
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", fs_to_ds_valid); end
        n_tests++; if (fs_to_ds_bus[31:0] !== 32'h1bff_fffc) begin n_fail++; $display("FAIL reset_pc: got %h exp 1bfffffc", fs_to_ds_bus[31:0]); end
        n_tests++; if (inst_sram_we !== 4'h0 || inst_sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_tieoff: we %h wdata %h exp 0", inst_sram_we, inst_sram_wdata); end
        next_cycle();
        drive(1'b1, 34'h0);
    endtask

    task automatic test_fetch_seq();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        resetn = 1'b1;
        drive(1'b1, 34'h0);
        for (int i = 0; i < 3; i++) begin
            push_req(RST_PC + 32'(4 * i));
            if (i > 0) push_del(RST_PC + 32'(4 * (i - 1)));
            @(negedge clk);
            if (i == 0) begin
                n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL seq_first_req: en %b addr %h exp 1 %h", inst_sram_en, inst_sram_addr, RST_PC); end
                n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_valid: got %b exp 0", fs_to_ds_valid); end
            end
            next_cycle();
        end
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL seq_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL seq_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL seq_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL seq_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_stall();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 34'h0);
            @(negedge clk);
            n_tests++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d]: got %b exp 0", i, inst_sram_en); end
            n_tests++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {mem_word(32'h1c00_0008), 32'h1c00_0008}) begin n_fail++; $display("FAIL stall_hold[%0d]: valid %b bus %h exp 1 %h", i, fs_to_ds_valid, fs_to_ds_bus, {mem_word(32'h1c00_0008), 32'h1c00_0008}); end
            next_cycle();
        end
        drive(1'b1, 34'h0);
        push_req(32'h1c00_000c); push_del(32'h1c00_0008);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_000c) begin n_fail++; $display("FAIL stall_release_req: en %b addr %h exp 1 1c00000c", inst_sram_en, inst_sram_addr); end
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL stall_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL stall_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL stall_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL stall_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_redirect();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        drive(1'b1, 34'h0); push_req(32'h1c00_0010); push_del(32'h1c00_000c);
        next_cycle();
        drive(1'b1, br_take(32'h1c00_0100)); push_req(32'h1c00_0100);
        @(negedge clk);
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash: got %b exp 0", fs_to_ds_valid); end
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin n_fail++; $display("FAIL redir_req: en %b addr %h exp 1 1c000100", inst_sram_en, inst_sram_addr); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h1c00_0104); push_del(32'h1c00_0100);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL redir_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL redir_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL redir_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL redir_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_br_seen();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        drive(1'b0, br_take(32'h1c00_0200)); push_req(32'h1c00_0200);
        @(negedge clk);
        n_tests++; if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c00_0200) begin n_fail++; $display("FAIL seen_first: valid %b addr %h exp 0 1c000200", fs_to_ds_valid, inst_sram_addr); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, br_take(32'h1c00_0200));
            @(negedge clk);
            n_tests++; if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[31:0] !== 32'h1c00_0200) begin n_fail++; $display("FAIL seen_hold[%0d]: en %b valid %b pc %h exp 0 1 1c000200", i, inst_sram_en, fs_to_ds_valid, fs_to_ds_bus[31:0]); end
            next_cycle();
        end
        drive(1'b1, br_take(32'h1c00_0200)); push_req(32'h1c00_0204); push_del(32'h1c00_0200);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0204) begin n_fail++; $display("FAIL seen_leave: en %b addr %h exp 1 1c000204", inst_sram_en, inst_sram_addr); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h1c00_0208); push_del(32'h1c00_0204);
        next_cycle();
        drive(1'b1, br_take(32'h1c00_0240)); push_req(32'h1c00_0240);
        @(negedge clk);
        n_tests++; if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c00_0240) begin n_fail++; $display("FAIL seen_cleared: valid %b addr %h exp 0 1c000240", fs_to_ds_valid, inst_sram_addr); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h1c00_0244); push_del(32'h1c00_0240);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL seen_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL seen_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL seen_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL seen_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        drive(1'b1, br_take(32'h1c00_0500)); push_req(32'h1c00_0500);
        next_cycle();
        drive(1'b1, br_take(32'h1c00_0600)); push_req(32'h1c00_0600);
        @(negedge clk);
        n_tests++; if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c00_0600) begin n_fail++; $display("FAIL b2b_second: valid %b addr %h exp 0 1c000600", fs_to_ds_valid, inst_sram_addr); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h1c00_0604); push_del(32'h1c00_0600);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL b2b_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL b2b_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL b2b_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_br_stall();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, {1'b1, 1'b0, 32'h0});
            @(negedge clk);
            n_tests++; if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus[31:0] !== 32'h1c00_0604) begin n_fail++; $display("FAIL stall1[%0d]: en %b valid %b pc %h exp 0 0 1c000604", i, inst_sram_en, fs_to_ds_valid, fs_to_ds_bus[31:0]); end
            next_cycle();
        end
        // Flushed slot: fetch resumes even though decode is not accepting.
        drive(1'b0, 34'h0); push_req(32'h1c00_0608);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0608 || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush: en %b addr %h valid %b exp 1 1c000608 0", inst_sram_en, inst_sram_addr, fs_to_ds_valid); end
        next_cycle();
        drive(1'b0, 34'h0);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL stall_refill: en %b valid %b exp 0 1", inst_sram_en, fs_to_ds_valid); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, {1'b1, 1'b0, 32'h0});
            @(negedge clk);
            n_tests++; if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL stall2[%0d]: en %b valid %b exp 0 0", i, inst_sram_en, fs_to_ds_valid); end
            next_cycle();
        end
        drive(1'b1, br_take(32'h1c00_0300)); push_req(32'h1c00_0300);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0300) begin n_fail++; $display("FAIL stall_then_br: en %b addr %h exp 1 1c000300", inst_sram_en, inst_sram_addr); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h1c00_0304); push_del(32'h1c00_0300);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL brstall_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL brstall_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL brstall_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL brstall_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        drive(1'b1, br_take(32'h1c00_0040)); push_req(32'h1c00_0040);
        next_cycle();
        drive(1'b0, 34'h0);
        #1;
        n_tests++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[31:0] !== 32'h1c00_0040) begin n_fail++; $display("FAIL rmid_pre: valid %b pc %h exp 1 1c000040", fs_to_ds_valid, fs_to_ds_bus[31:0]); end
        #1 resetn = 1'b0;
        #1;
        n_tests++; if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus[31:0] !== 32'h1bff_fffc) begin n_fail++; $display("FAIL rmid_async: en %b valid %b pc %h exp 0 0 1bfffffc", inst_sram_en, fs_to_ds_valid, fs_to_ds_bus[31:0]); end
        drive(1'b1, 34'h0);
        next_cycle();
        resetn = 1'b1; push_req(RST_PC);
        @(negedge clk);
        n_tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_first: en %b addr %h valid %b exp 1 %h 0", inst_sram_en, inst_sram_addr, fs_to_ds_valid, RST_PC); end
        next_cycle();
        push_req(RST_PC + 32'd4); push_del(RST_PC);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL rmid_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rmid_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL rmid_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL rmid_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

`ifdef IF_INST_BUF_EN
    task automatic test_inst_buf();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        scramble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 34'h0);
            @(negedge clk);
            n_tests++; if (fs_to_ds_bus !== {mem_word(RST_PC + 32'd4), RST_PC + 32'd4}) begin n_fail++; $display("FAIL buf_hold[%0d]: got %h exp %h", i, fs_to_ds_bus, {mem_word(RST_PC + 32'd4), RST_PC + 32'd4}); end
            next_cycle();
        end
        scramble = 1'b0;
        drive(1'b1, 34'h0); push_req(RST_PC + 32'd8); push_del(RST_PC + 32'd4);
        next_cycle();
        push_req(RST_PC + 32'd12); push_del(RST_PC + 32'd8);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL buf_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL buf_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL buf_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL buf_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask
`endif

    task automatic test_wrap();
        logic [31:0] e, o;
        logic [63:0] e64, o64;
        drive(1'b1, br_take(32'hffff_fffe)); push_req(32'hffff_fffe);
        @(negedge clk);
        n_tests++; if (inst_sram_addr !== 32'hffff_fffe || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_target: addr %h valid %b exp fffffffe 0", inst_sram_addr, fs_to_ds_valid); end
        next_cycle();
        drive(1'b1, 34'h0); push_req(32'h0000_0002); push_del(32'hffff_fffe);
        next_cycle();
        push_req(32'h0000_0006); push_del(32'h0000_0002);
        next_cycle();
        n_tests++; if (obs_req.size() != exp_req.size()) begin n_fail++; $display("FAIL wrap_req_count: got %0d exp %0d", obs_req.size(), exp_req.size()); end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front(); o = 32'hxxxx_xxxx; if (obs_req.size() > 0) o = obs_req.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL wrap_req: got %h exp %h", o, e); end
        end
        n_tests++; if (obs_del.size() != exp_del.size()) begin n_fail++; $display("FAIL wrap_del_count: got %0d exp %0d", obs_del.size(), exp_del.size()); end
        while (exp_del.size() > 0) begin
            e64 = exp_del.pop_front(); o64 = 64'hx; if (obs_del.size() > 0) o64 = obs_del.pop_front();
            n_tests++; if (o64 !== e64) begin n_fail++; $display("FAIL wrap_del: got %h exp %h", o64, e64); end
        end
        obs_req.delete(); obs_del.delete();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = 34'h0;
        scramble   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect();
        test_br_seen();
        test_back_to_back();
        test_br_stall();
        test_reset_mid();
`ifdef IF_INST_BUF_EN
        test_inst_buf();
`endif
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
